// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the decoded instruction for the execute
// stage, detects load-use hazards against EX, inserts bubbles on stall or
// flush, and counts inserted bubbles (saturating) for performance debug.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm_ext,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc_plus4,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_ext,
  output logic [31:0] ex_operand_b,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_write_reg,
  output logic [3:0]  ex_alu_op,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        stall,
  output logic [15:0] bubble_count
);

  logic        valid_q, valid_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imm_ext_q, imm_ext_d;
  logic [31:0] operand_b_q, operand_b_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  logic hazard;
  logic bubble;

  // Load-use hazard: EX holds a load whose destination the decode instruction reads.
  always_comb begin
    hazard = valid_q & mem_read_q & (write_reg_q != 5'd0) & id_valid &
             ((write_reg_q == id_rs) | (id_uses_rt & (write_reg_q == id_rt)));
    // Flush discards the decode instruction, so there is nothing to hold.
    stall  = hazard & ~flush;
    bubble = flush | hazard;
  end

  // Next-state for the pipeline register; data fields always load, control is
  // zeroed on a bubble and gated by id_valid otherwise.
  always_comb begin
    pc_plus4_d   = id_pc_plus4;
    rs_data_d    = id_rs_data;
    rt_data_d    = id_rt_data;
    imm_ext_d    = id_imm_ext;
    operand_b_d  = id_alu_src ? id_imm_ext : id_rt_data;
    rs_d         = id_rs;
    rt_d         = id_rt;
    write_reg_d  = id_reg_dst ? id_rd : id_rt;
    alu_op_d     = id_alu_op;
    valid_d      = id_valid;
    mem_read_d   = id_mem_read   & id_valid;
    mem_write_d  = id_mem_write  & id_valid;
    reg_write_d  = id_reg_write  & id_valid;
    mem_to_reg_d = id_mem_to_reg & id_valid;
    bubble_count_d = bubble_count_q;
    if (bubble) begin
      valid_d      = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_op_d     = 4'd0;
      write_reg_d  = 5'd0;
      if (id_valid && (bubble_count_q != 16'hFFFF))
        bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  // Register bank with asynchronous clear of every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      pc_plus4_q     <= 32'd0;
      rs_data_q      <= 32'd0;
      rt_data_q      <= 32'd0;
      imm_ext_q      <= 32'd0;
      operand_b_q    <= 32'd0;
      rs_q           <= 5'd0;
      rt_q           <= 5'd0;
      write_reg_q    <= 5'd0;
      alu_op_q       <= 4'd0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      bubble_count_q <= 16'd0;
    end else begin
      valid_q        <= valid_d;
      pc_plus4_q     <= pc_plus4_d;
      rs_data_q      <= rs_data_d;
      rt_data_q      <= rt_data_d;
      imm_ext_q      <= imm_ext_d;
      operand_b_q    <= operand_b_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      write_reg_q    <= write_reg_d;
      alu_op_q       <= alu_op_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc_plus4   = pc_plus4_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm_ext    = imm_ext_q;
  assign ex_operand_b  = operand_b_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_write_reg  = write_reg_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized and directed bench for id_ex_reg against a behavioural model of
// the EX-stage contents.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt, id_alu_src, id_reg_dst;
  logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, flush;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, stall;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_operand_b;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic [3:0]  ex_alu_op;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_operand_b(ex_operand_b),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg), .ex_alu_op(ex_alu_op),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .stall(stall),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  // Model of what EX must hold.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm, opb;
    logic [4:0]  rs, rt, wr;
    logic [3:0]  op;
    logic        mr, mw, rw, m2r;
    logic        data_known;
    int          count;
  } ex_t;

  ex_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t model_reset();
    ex_t r;
    r.valid = 0; r.pc = 0; r.rsd = 0; r.rtd = 0; r.imm = 0; r.opb = 0;
    r.rs = 0; r.rt = 0; r.wr = 0; r.op = 0; r.mr = 0; r.mw = 0; r.rw = 0; r.m2r = 0;
    r.data_known = 1; r.count = 0;
    return r;
  endfunction

  // The decode instruction reads the register that the load in EX will write.
  function automatic bit model_hazard();
    if (!(m.valid && m.mr && m.wr != 0 && id_valid)) return 0;
    return (m.wr == id_rs) || (id_uses_rt && m.wr == id_rt);
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = m;
    if (flush || model_hazard()) begin
      n.valid = 0; n.mr = 0; n.mw = 0; n.rw = 0; n.m2r = 0; n.op = 0; n.wr = 0;
      n.data_known = 0;
      if (id_valid && n.count < 65535) n.count = n.count + 1;
    end else begin
      n.valid = id_valid;
      n.pc = id_pc_plus4; n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm_ext;
      n.opb = id_alu_src ? id_imm_ext : id_rt_data;
      n.rs = id_rs; n.rt = id_rt;
      n.wr = id_reg_dst ? id_rd : id_rt;
      n.op = id_alu_op;
      n.mr = id_mem_read & id_valid; n.mw = id_mem_write & id_valid;
      n.rw = id_reg_write & id_valid; n.m2r = id_mem_to_reg & id_valid;
      n.data_known = 1;
    end
    return n;
  endfunction

  task automatic compare_outputs();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
    chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
    chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk("ex_mem_to_reg", {31'd0, ex_mem_to_reg}, {31'd0, m.m2r});
    chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, m.op});
    chk("ex_write_reg", {27'd0, ex_write_reg}, {27'd0, m.wr});
    chk("bubble_count", {16'd0, bubble_count}, m.count);
    if (m.data_known) begin
      chk("ex_pc_plus4", ex_pc_plus4, m.pc);
      chk("ex_rs_data", ex_rs_data, m.rsd);
      chk("ex_rt_data", ex_rt_data, m.rtd);
      chk("ex_imm_ext", ex_imm_ext, m.imm);
      chk("ex_operand_b", ex_operand_b, m.opb);
      chk("ex_rs", {27'd0, ex_rs}, {27'd0, m.rs});
      chk("ex_rt", {27'd0, ex_rt}, {27'd0, m.rt});
    end
  endtask

  // One cycle: check stall against the model, clock, then check EX contents.
  task automatic step();
    ex_t n;
    #1;
    chk("stall", {31'd0, stall}, {31'd0, model_hazard() && !flush});
    n = model_next();
    @(posedge clk);
    #1;
    m = n;
    compare_outputs();
  endtask

  task automatic randomize_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm_ext = $urandom;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_uses_rt = 1'($urandom); id_alu_op = 4'($urandom);
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic set_idle();
    id_valid = 1; id_pc_plus4 = 32'h100; id_rs_data = 32'h11; id_rt_data = 32'h22;
    id_imm_ext = 32'h4; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_alu_op = 4'd2; id_alu_src = 0; id_reg_dst = 1; id_mem_read = 0;
    id_mem_write = 0; id_reg_write = 1; id_mem_to_reg = 0; flush = 0;
  endtask

  task automatic set_lw(input logic [4:0] dst);
    set_idle();
    id_rs = 5'd1; id_rt = dst; id_reg_dst = 0; id_alu_src = 1;
    id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  initial begin
    rst_n = 0;
    m = model_reset();
    // Reset held with random inputs: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      @(posedge clk);
      #1;
      chk("reset_stall", {31'd0, stall}, 32'd0);
      compare_outputs();
    end
    @(negedge clk);
    rst_n = 1;

    // First capture after release: ALU op with immediate operand.
    set_idle();
    id_alu_src = 1; id_imm_ext = 32'hFFFF_FFF0; id_reg_dst = 0; id_rt = 5'd5; id_rd = 5'd9;
    step();
    chk("lit_operand_b", ex_operand_b, 32'hFFFF_FFF0);
    chk("lit_write_reg", {27'd0, ex_write_reg}, 32'd5);
    chk("lit_valid", {31'd0, ex_valid}, 32'd1);

    // lw $8 then add using rs=8: one stall cycle, one bubble.
    set_lw(5'd8);
    step();
    set_idle(); id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd10; id_uses_rt = 1;
    #1 chk("lit_stall_rs", {31'd0, stall}, 32'd1);
    step();
    chk("lit_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lit_count_1", {16'd0, bubble_count}, 32'd1);
    #1 chk("lit_stall_clear", {31'd0, stall}, 32'd0);
    step();
    chk("lit_add_in_ex", {27'd0, ex_write_reg}, 32'd10);

    // lw $8 then sw reading rt=8.
    set_lw(5'd8);
    step();
    set_idle(); id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1; id_mem_write = 1; id_reg_write = 0;
    #1 chk("lit_stall_rt", {31'd0, stall}, 32'd1);
    id_uses_rt = 0;
    #1 chk("lit_nostall_rt_unused", {31'd0, stall}, 32'd0);
    id_uses_rt = 1;
    // Flush together with the hazard: bubble, no stall, count +1.
    flush = 1;
    #1 chk("lit_flush_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("lit_flush_count", {16'd0, bubble_count}, 32'd2);
    chk("lit_flush_ctl", {27'd0, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);

    // A load into $0 never stalls.
    set_lw(5'd0);
    step();
    set_idle(); id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
    #1 chk("lit_nostall_r0", {31'd0, stall}, 32'd0);
    step();

    // Randomized traffic with small register index space to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    // Reset asserted in the middle of a stall.
    set_lw(5'd2);
    step();
    set_idle(); id_rs = 5'd2;
    #1 chk("lit_stall_pre_reset", {31'd0, stall}, 32'd1);
    rst_n = 0;
    #1;
    m = model_reset();
    chk("reset_mid_stall", {31'd0, stall}, 32'd0);
    compare_outputs();
    @(negedge clk);
    rst_n = 1;

    // Saturate the bubble counter with continuous flushes.
    set_idle(); flush = 1;
    for (int i = 0; i < 70000; i++) step();
    chk("lit_saturated", {16'd0, bubble_count}, 32'h0000_FFFF);

    // Asynchronous reset clears the counter without a clock edge.
    #2 rst_n = 0;
    #1;
    m = model_reset();
    chk("lit_async_count", {16'd0, bubble_count}, 32'd0);
    compare_outputs();
    @(negedge clk);
    rst_n = 1;
    set_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
